// File: rtl/gate_tester_pkg.sv
// Shared types and constants for the two-input gate tester.
package gate_tester_pkg;

  // Tester sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Encodings of the expected gate function.
  localparam logic [1:0] OP_AND  = 2'd0;
  localparam logic [1:0] OP_OR   = 2'd1;
  localparam logic [1:0] OP_XOR  = 2'd2;
  localparam logic [1:0] OP_NAND = 2'd3;

  // A two-input gate has four input combinations to exercise.
  localparam int NUM_VECTORS = 4;

endpackage

// File: rtl/gate_tester_gate_model.sv
// Golden two-input gate: optional input bubbles followed by the selected function.
module gate_model
  import gate_tester_pkg::*;
#(
  parameter logic [1:0] BubblesMask = 2'b00,
  parameter logic [1:0] GateOp      = OP_AND
) (
  input  logic a,
  input  logic b,
  output logic y
);

  logic a_eff;
  logic b_eff;

  assign a_eff = a ^ BubblesMask[0];
  assign b_eff = b ^ BubblesMask[1];

  // Apply the selected gate function to the (possibly inverted) inputs.
  always_comb begin
    y = 1'b0;
    case (GateOp)
      OP_AND:  y = a_eff & b_eff;
      OP_OR:   y = a_eff | b_eff;
      OP_XOR:  y = a_eff ^ b_eff;
      default: y = ~(a_eff & b_eff);
    endcase
  end

endmodule

// File: rtl/gate_tester.sv
// Exhaustive tester for a two-input gate: walks the four input vectors,
// holds each for SettleCycles+1 cycles, samples the gate output on the last
// edge of the window and records mismatches against a golden gate model.
//
// Handshake: start is a request sampled only in IDLE; once accepted busy is
// high for the whole run, then done pulses for exactly one cycle with busy
// low, and pass/fail_vector/err_count are valid from that cycle until the
// next accepted start.
module gate_tester
  import gate_tester_pkg::*;
#(
  parameter logic [1:0] BubblesMask  = 2'b00,
  parameter logic [1:0] GateOp       = OP_AND,
  parameter int         SettleCycles = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  output logic       input1,
  output logic       input2,
  input  logic       result,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_vector,
  output logic [2:0] err_count,
  output state_t     dbg_state
);

  localparam logic [3:0] SETTLE_LAST = 4'(SettleCycles);
  localparam logic [1:0] LAST_VEC    = 2'(NUM_VECTORS - 1);

  state_t      state_q, state_d;
  logic [1:0]  vec_q, vec_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  fail_q, fail_d;
  logic [2:0]  err_q, err_d;
  logic        pass_q, pass_d;
  logic        expected;
  logic        mismatch;

  gate_model #(
    .BubblesMask (BubblesMask),
    .GateOp      (GateOp)
  ) u_gate_model (
    .a (input1),
    .b (input2),
    .y (expected)
  );

  assign mismatch    = (result != expected);
  assign pass        = pass_q;
  assign fail_vector = fail_q;
  assign err_count   = err_q;
  assign dbg_state   = state_q;

  // Next-state, result bookkeeping and stimulus/status decode.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    err_d   = err_q;
    pass_d  = pass_q;
    input1  = 1'b0;
    input2  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          vec_d   = '0;
          cnt_d   = '0;
          fail_d  = '0;
          err_d   = '0;
          pass_d  = 1'b0;
        end
      end
      DRIVE: begin
        busy   = 1'b1;
        input1 = vec_q[0];
        input2 = vec_q[1];
        if (cnt_q == SETTLE_LAST) begin
          // Last edge of the settle window: sample the gate output.
          cnt_d = '0;
          if (mismatch) begin
            fail_d[vec_q] = 1'b1;
            err_d         = err_q + 3'd1;
          end
          if (vec_q == LAST_VEC) begin
            state_d = DONE;
            vec_d   = '0;
            pass_d  = (err_q == 3'd0) && !mismatch;
          end else begin
            vec_d = vec_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      fail_q  <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
    end
  end

endmodule

// File: tb/tb_gate_tester.sv
// Bench for gate_tester: four instances with different gate configurations,
// each looped back to a bench-driven gate that can be correct, stuck low,
// inverted-XOR or correct with chosen per-vector faults.
module tb_gate_tester;
  import gate_tester_pkg::*;

  localparam int S_TAB    [4] = '{1, 2, 3, 15};
  localparam int OP_TAB   [4] = '{0, 0, 2, 3};
  localparam int MASK_TAB [4] = '{1, 0, 0, 2};

  // clock / reset
  logic clock;
  logic reset;
  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic       start       [4];
  logic       input1      [4];
  logic       input2      [4];
  logic       result      [4];
  logic       busy        [4];
  logic       done        [4];
  logic       pass        [4];
  logic [3:0] fail_vector [4];
  logic [2:0] err_count   [4];
  state_t     dbg_state   [4];

  int         mode_r  [4];
  logic [3:0] emask_r [4];

  int n_checks = 0;
  int n_pass   = 0;

  // scoreboard: {pass, err_count, fail_vector} expected at the end of each run
  logic [7:0] exp_q [$];
  logic [7:0] last_exp;

  gate_tester #(.BubblesMask(2'd1), .GateOp(2'd0), .SettleCycles(1)) u_dut0 (
    .clock(clock), .reset(reset), .start(start[0]), .input1(input1[0]),
    .input2(input2[0]), .result(result[0]), .busy(busy[0]), .done(done[0]),
    .pass(pass[0]), .fail_vector(fail_vector[0]), .err_count(err_count[0]),
    .dbg_state(dbg_state[0]));
  gate_tester #(.BubblesMask(2'd0), .GateOp(2'd0), .SettleCycles(2)) u_dut1 (
    .clock(clock), .reset(reset), .start(start[1]), .input1(input1[1]),
    .input2(input2[1]), .result(result[1]), .busy(busy[1]), .done(done[1]),
    .pass(pass[1]), .fail_vector(fail_vector[1]), .err_count(err_count[1]),
    .dbg_state(dbg_state[1]));
  gate_tester #(.BubblesMask(2'd0), .GateOp(2'd2), .SettleCycles(3)) u_dut2 (
    .clock(clock), .reset(reset), .start(start[2]), .input1(input1[2]),
    .input2(input2[2]), .result(result[2]), .busy(busy[2]), .done(done[2]),
    .pass(pass[2]), .fail_vector(fail_vector[2]), .err_count(err_count[2]),
    .dbg_state(dbg_state[2]));
  gate_tester #(.BubblesMask(2'd2), .GateOp(2'd3), .SettleCycles(15)) u_dut3 (
    .clock(clock), .reset(reset), .start(start[3]), .input1(input1[3]),
    .input2(input2[3]), .result(result[3]), .busy(busy[3]), .done(done[3]),
    .pass(pass[3]), .fail_vector(fail_vector[3]), .err_count(err_count[3]),
    .dbg_state(dbg_state[3]));

  // Reference gate straight from the function definition.
  function automatic logic ref_out(int d, logic a, logic b);
    logic ai, bi;
    ai = a ^ MASK_TAB[d][0];
    bi = b ^ MASK_TAB[d][1];
    case (OP_TAB[d])
      0:       return ai & bi;
      1:       return ai | bi;
      2:       return ai ^ bi;
      default: return ~(ai & bi);
    endcase
  endfunction

  // The gate under test as seen by each tester.
  function automatic logic result_model(int d, int mode, logic [3:0] em,
                                        logic a, logic b);
    case (mode)
      0:       return ref_out(d, a, b);
      1:       return 1'b0;
      2:       return ~(a ^ b);
      default: return ref_out(d, a, b) ^ em[{b, a}];
    endcase
  endfunction

  function automatic logic [3:0] exp_fail(int d, int mode, logic [3:0] em);
    logic [3:0] f;
    logic [1:0] k2;
    f = '0;
    for (int k = 0; k < 4; k++) begin
      k2 = 2'(k);
      f[k] = (result_model(d, mode, em, k2[0], k2[1]) !== ref_out(d, k2[0], k2[1]));
    end
    return f;
  endfunction

  always_comb begin
    for (int d = 0; d < 4; d++)
      result[d] = result_model(d, mode_r[d], emask_r[d], input1[d], input2[d]);
  end

  // driver: one full run on tester d, checked cycle by cycle
  task automatic run_one(input int d, input int mode, input logic [3:0] em,
                         input bit repulse);
    int s1, total, n, nsamp;
    bit seen;
    logic [3:0] fexp, part;
    logic [7:0] exp_v;
    s1    = S_TAB[d] + 1;
    total = 4 * s1;
    fexp  = exp_fail(d, mode, em);
    exp_q.push_back({($countones(fexp) == 0), 3'($countones(fexp)), fexp});
    mode_r[d]  = mode;
    emask_r[d] = em;
    @(negedge clock); start[d] = 1'b1;
    @(negedge clock); start[d] = 1'b0;
    seen = 1'b0;
    for (n = 0; n < total + 8; n++) begin
      if (repulse && n == 2) start[d] = 1'b1;
      if (repulse && n == 3) start[d] = 1'b0;
      if (done[d]) begin
        seen = 1'b1;
        break;
      end
      nsamp = n / s1;
      part  = '0;
      for (int k = 0; k < 4; k++) if (k < nsamp) part[k] = fexp[k];
      n_checks++;
      if (busy[d] !== 1'b1 || {input2[d], input1[d]} !== 2'(nsamp) || pass[d] !== 1'b0
          || fail_vector[d] !== part || err_count[d] !== 3'($countones(part))) begin
        $display("FAIL run_cycle d=%0d n=%0d: busy=%b vec=%b pass=%b fv=%b ec=%0d, required busy=1 vec=%b pass=0 fv=%b ec=%0d",
                 d, n, busy[d], {input2[d], input1[d]}, pass[d], fail_vector[d], err_count[d],
                 2'(nsamp), part, $countones(part));
      end else n_pass++;
      @(negedge clock);
    end
    n_checks++;
    if (!seen || n != total) begin
      $display("FAIL done_latency d=%0d: done at cycle %0d (seen=%0d), required %0d", d, n, seen, total);
    end else n_pass++;
    exp_v    = exp_q.pop_front();
    last_exp = exp_v;
    n_checks++;
    if ({pass[d], err_count[d], fail_vector[d]} !== exp_v || busy[d] !== 1'b0) begin
      $display("FAIL run_result d=%0d: pass=%b ec=%0d fv=%b busy=%b, required pass=%b ec=%0d fv=%b busy=0",
               d, pass[d], err_count[d], fail_vector[d], busy[d], exp_v[7], exp_v[6:4], exp_v[3:0]);
    end else n_pass++;
    @(negedge clock);
    n_checks++;
    if (done[d] !== 1'b0 || busy[d] !== 1'b0 || input1[d] !== 1'b0 || input2[d] !== 1'b0
        || {pass[d], err_count[d], fail_vector[d]} !== exp_v) begin
      $display("FAIL after_done d=%0d: done=%b busy=%b in=%b%b res=%h, required 0 0 00 %h",
               d, done[d], busy[d], input2[d], input1[d],
               {pass[d], err_count[d], fail_vector[d]}, exp_v);
    end else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    for (int d = 0; d < 4; d++) begin
      n_checks++;
      if (dbg_state[d] !== IDLE || busy[d] !== 1'b0 || done[d] !== 1'b0 || pass[d] !== 1'b0
          || input1[d] !== 1'b0 || input2[d] !== 1'b0 || fail_vector[d] !== 4'd0
          || err_count[d] !== 3'd0) begin
        $display("FAIL reset_state d=%0d: st=%0d busy=%b done=%b pass=%b in=%b%b fv=%b ec=%0d, required all 0",
                 d, dbg_state[d], busy[d], done[d], pass[d], input2[d], input1[d],
                 fail_vector[d], err_count[d]);
      end else n_pass++;
    end
    reset = 1'b0;
  endtask

  task automatic test_loopback();
    run_one(0, 0, 4'b0000, 1'b0);
  endtask

  task automatic test_tied_low();
    run_one(1, 1, 4'b0000, 1'b0);
  endtask

  task automatic test_inverted_xor();
    run_one(2, 2, 4'b0000, 1'b0);
  endtask

  task automatic test_long_settle();
    run_one(3, 0, 4'b0000, 1'b0);
    run_one(3, 3, 4'b0110, 1'b0);
  endtask

  task automatic test_hold();
    int w;
    run_one(1, 3, 4'b1001, 1'b0);
    w = $urandom_range(2, 6);
    repeat (w) @(negedge clock);
    n_checks++;
    if ({pass[1], err_count[1], fail_vector[1]} !== last_exp) begin
      $display("FAIL hold_between_runs: got %h, required %h", {pass[1], err_count[1], fail_vector[1]}, last_exp);
    end else n_pass++;
  endtask

  task automatic test_mid_restart();
    run_one(0, 3, 4'b0100, 1'b1);
    run_one(2, 0, 4'b0000, 1'b1);
  endtask

  task automatic test_reset_mid_run();
    int n;
    bit saw_done;
    mode_r[0] = 0;
    @(negedge clock); start[0] = 1'b1;
    @(negedge clock); start[0] = 1'b0;
    for (n = 0; n < 4; n++) @(negedge clock);
    n_checks++;
    if ({input2[0], input1[0]} !== 2'b10 || busy[0] !== 1'b1) begin
      $display("FAIL reset_mid_vec2: vec=%b busy=%b, required vec=10 busy=1", {input2[0], input1[0]}, busy[0]);
    end else n_pass++;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    n_checks++;
    if (dbg_state[0] !== IDLE || busy[0] !== 1'b0 || done[0] !== 1'b0 || pass[0] !== 1'b0
        || input1[0] !== 1'b0 || input2[0] !== 1'b0 || fail_vector[0] !== 4'd0 || err_count[0] !== 3'd0) begin
      $display("FAIL reset_mid_run: st=%0d busy=%b done=%b pass=%b in=%b%b fv=%b ec=%0d, required all 0",
               dbg_state[0], busy[0], done[0], pass[0], input2[0], input1[0], fail_vector[0], err_count[0]);
    end else n_pass++;
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clock);
      if (done[0] || busy[0]) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done) begin
      $display("FAIL reset_no_done: activity after reset seen=1, required 0");
    end else n_pass++;
    run_one(0, 3, 4'b1010, 1'b0);
  endtask

  task automatic test_back_to_back();
    int done_at [$];
    mode_r[0] = 0;
    @(negedge clock); start[0] = 1'b1;
    @(negedge clock);
    for (int n = 0; n < 30; n++) begin
      if (done[0]) done_at.push_back(n);
      if (n == 9) begin
        n_checks++;
        if (busy[0] !== 1'b0 || done[0] !== 1'b0 || dbg_state[0] !== IDLE) begin
          $display("FAIL b2b_idle: busy=%b done=%b st=%0d, required 0 0 IDLE", busy[0], done[0], dbg_state[0]);
        end else n_pass++;
      end
      if (n == 10) begin
        n_checks++;
        if (busy[0] !== 1'b1) begin
          $display("FAIL b2b_restart: busy=%b, required 1", busy[0]);
        end else n_pass++;
      end
      if (n == 11) start[0] = 1'b0;
      @(negedge clock);
    end
    n_checks++;
    if (done_at.size() != 2 || done_at[0] != 8 || done_at[1] != 18) begin
      $display("FAIL b2b_done_times: count=%0d first=%0d second=%0d, required 2 at 8 and 18",
               done_at.size(), (done_at.size() > 0) ? done_at[0] : -1,
               (done_at.size() > 1) ? done_at[1] : -1);
    end else n_pass++;
  endtask

  task automatic test_random();
    int d, mode;
    logic [3:0] em;
    for (int i = 0; i < 12; i++) begin
      d    = $urandom_range(0, 2);
      mode = $urandom_range(0, 3);
      em   = 4'($urandom_range(0, 15));
      run_one(d, mode, em, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    for (int d = 0; d < 4; d++) begin
      start[d]   = 1'b0;
      mode_r[d]  = 0;
      emask_r[d] = 4'd0;
    end
    reset = 1'b1;
    test_reset();
    test_loopback();
    test_tied_low();
    test_inverted_xor();
    test_hold();
    test_mid_restart();
    test_reset_mid_run();
    test_back_to_back();
    test_long_settle();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gate_tester.md
GATE_TESTER -- requirements
Module: gate_tester

Interface
REQ-001 SHALL have parameter BubblesMask, [1:0], default 0: bit i set means input i of the expected gate is inverted (bit0 = input1, bit1 = input2).
REQ-002 SHALL have parameter GateOp, [1:0], default 0: expected function is 0 AND, 1 OR, 2 XOR, 3 NAND.
REQ-003 SHALL have parameter SettleCycles, integer 1..15, default 1: extra cycles each vector is held before its sample.
REQ-004 SHALL have port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: request a test run, sampled only in IDLE.
REQ-007 SHALL have port input1, output, 1: stimulus to the gate-under-test input1.
REQ-008 SHALL have port input2, output, 1: stimulus to the gate-under-test input2.
REQ-009 SHALL have port result, input, 1: gate-under-test output.
REQ-010 SHALL have port busy, output, 1: high while a run is in progress.
REQ-011 SHALL have port done, output, 1: one-cycle pulse when a run completes.
REQ-012 SHALL have port pass, output, 1: last run had zero mismatches; held until the next start.
REQ-013 SHALL have port fail_vector, output, 4: bit k set means vector k mismatched in the last run.
REQ-014 SHALL have port err_count, output, 3: mismatch count of the last run, 0..4.

Function
REQ-015 SHALL implement FSM states IDLE, DRIVE, DONE.
REQ-016 IDLE: a start sampled high at an edge SHALL enter DRIVE with vector index 0, clear fail_vector and err_count, clear pass, and set busy.
REQ-017 Vector k (0..3) SHALL drive input1 = k[0] and input2 = k[1]; in IDLE and DONE both SHALL be 0.
REQ-018 Each vector SHALL be held exactly SettleCycles+1 cycles, with result sampled at the last edge of that window.
REQ-019 Expected value SHALL be GateOp applied to (input1 XOR BubblesMask[0]) and (input2 XOR BubblesMask[1]).
REQ-020 On mismatch at a sample edge, the tester SHALL set fail_vector[k] and increment err_count at that same edge.
REQ-021 After the vector-3 sample the FSM SHALL enter DONE: done=1 and busy=0 for exactly one cycle, pass = (err_count after the final sample == 0); it then returns to IDLE.
REQ-022 Start-to-done latency SHALL be 4*(SettleCycles+1) cycles from the start edge to the edge asserting done.
REQ-023 start SHALL be ignored in DRIVE and DONE; a start held high SHALL begin a new run from the IDLE cycle after DONE.
REQ-024 fail_vector, err_count and pass SHALL hold their values between runs.
REQ-025 err_count SHALL saturate by construction (max 4) and never wrap.

Reset
REQ-026 reset SHALL, in any state including mid-run, force IDLE, vector index 0, settle counter 0, and input1/input2/busy/done/pass/fail_vector/err_count all 0 at the next edge.
REQ-027 reset SHALL take priority over start at the same edge.

Structure
REQ-028 Package gate_tester_pkg SHALL hold the state enum, the GateOp encodings, and the vector count constant (4).
REQ-029 The expected-value logic SHALL be a separate combinational sub-module, gate_model (inputs a, b; parameters BubblesMask and GateOp; output y).
REQ-030 The settle counter SHALL be 4 bits wide and the vector index 2 bits wide.

Verification
REQ-031 Loopback to a correct AND gate with BubblesMask=1 under the tester's GateOp=0, BubblesMask=1, SettleCycles=1, start pulsed -> done at the 8th edge after start, pass=1, fail_vector=0000, err_count=0.
REQ-032 result tied to 0, GateOp=0, BubblesMask=0 -> fail_vector=1000, err_count=1, pass=0.
REQ-033 result driven as the inverted XOR of the stimulus, GateOp=2 -> fail_vector=1111, err_count=4, pass=0.
REQ-034 reset asserted during vector 2 -> next cycle IDLE with all outputs 0; no done pulse; a later start runs a full 4-vector test.
REQ-035 start re-pulsed mid-run -> ignored, with done exactly once at the nominal cycle; start held high continuously -> back-to-back runs, each IDLE lasting 1 cycle.
REQ-036 SettleCycles=15 -> each vector held 16 cycles and done at edge 64.
